code_assembler: RTL
===================

// Module: code_assembler
// PURPOSE
//  Consumer end of the 4-bit digit-load interface: samples a loaded digit and its
//  load strobe, assembles NUM_DIGITS digits into one code word and hands the word
//  to the check/control logic over a valid/ack handshake. Sits between the digit
//  entry register and the code comparator; aborts stale partial entries on timeout.
// PARAMETERS
//  NUM_DIGITS      4      digits per code word (>=2)
//  DIGIT_W         4      bits per digit
//  TIMEOUT_CYCLES  50000  idle clocks allowed between digits in COLLECT; 0 = disabled
// PORTS
//  clk          in   1                    system clock, all state on posedge
//  rst          in   1                    asynchronous reset, active-low
//  digit_in     in   DIGIT_W              digit value, stable while digit_strobe=1
//  digit_strobe in   1                    load strobe from the digit register
//  clear        in   1                    synchronous abort of any entry in progress
//  code_ack     in   1                    consumer accepts code_out
//  code_out     out  NUM_DIGITS*DIGIT_W   assembled code, first digit in MS position
//  code_valid   out  1                    code_out complete and held
//  digit_count  out  clog2(NUM_DIGITS+1)  digits captured in current entry
//  busy         out  1                    1 in COLLECT
//  timeout_err  out  1                    one-cycle pulse: entry aborted by timeout
//  overrun      out  1                    one-cycle pulse: digit dropped in READY
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; code_out=0, code_valid=0, digit_count=0,
//    busy=0, timeout_err=0, overrun=0, strobe history=0, timeout counter=0.
//  - Digit event: digit_strobe=1 this cycle AND registered strobe sample=0 (rising
//    edge). Multi-cycle strobes yield one event; digit_in sampled in event cycle.
//  - FSM: IDLE -> COLLECT on event (digit 1 captured, count=1).
//    COLLECT: each event shifts code_out left DIGIT_W, digit into LS slot, count+1;
//    the event making count==NUM_DIGITS moves to READY, code_valid=1 next cycle.
//    READY: code_out/code_valid held until code_ack=1; then code_valid=0, count=0,
//    -> IDLE. Event in READY without ack: digit dropped, overrun pulses, state held.
//    Event and code_ack same cycle in READY: ack completes; the event starts a new
//    entry (-> COLLECT, count=1, code_out = {0..., digit}); code_valid=0.
//  - Latency: completing event at cycle N -> code_valid=1 at N+1.
//  - code_out in IDLE/COLLECT is the partial word, LS-aligned, upper slots 0;
//    entering COLLECT from IDLE zeroes upper slots.
//  - Timeout: counter clears on every event, counts each COLLECT cycle without one;
//    when it reaches TIMEOUT_CYCLES: code_out=0, count=0, -> IDLE, timeout_err
//    pulses one cycle. Event on the expiry cycle wins (captured, counter cleared).
//    Not active in IDLE or READY.
//  - clear=1: any state -> IDLE, code_out=0, count=0, code_valid=0, no pulses;
//    overrides events and ack in the same cycle. Strobe history still updates.
//  - code_ack outside READY ignored. busy = (state==COLLECT).
//  - rst asserted mid-entry or in READY: immediate return to reset values.
// TESTING
//  1 Strobes 1-cycle digits 3,7,0,9 -> code_valid=1 one cycle after 4th,
//    code_out=16'h3709, digit_count=4; ack -> code_valid=0, count=0, IDLE.
//  2 digit_strobe held 5 cycles with 4'h5 -> exactly one digit, count=1, code_out=16'h0005.
//  3 TIMEOUT_CYCLES=10; digits 1,2 then idle -> timeout_err one pulse 10 cycles after
//    digit 2; code_out=0, count=0, busy=0; digit 2 on expiry cycle instead -> captured.
//  4 READY with 16'h1234, event 4'hA no ack -> overrun pulse, code_out stays 16'h1234;
//    event 4'hB with ack same cycle -> code_valid=0, count=1, code_out=16'h000B.
//  5 clear with event in COLLECT after 2 digits -> IDLE, code_out=0, count=0, no capture.
//  6 rst=0 asynchronously mid-cycle in COLLECT and in READY -> all outputs 0 at once.

Source files
------------

// File: rtl/code_assembler_if.sv
// Digit-load and code-handoff signals between the digit register, the assembler
// and the code comparator. The slave modport is the assembler side.
interface code_assembler_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4
);
    localparam int W  = NUM_DIGITS * DIGIT_W;
    localparam int CW = $clog2(NUM_DIGITS + 1);

    logic [DIGIT_W-1:0] digit_in;
    logic               digit_strobe;
    logic               clear;
    logic               code_ack;
    logic [W-1:0]       code_out;
    logic               code_valid;
    logic [CW-1:0]      digit_count;
    logic               busy;
    logic               timeout_err;
    logic               overrun;
    logic [1:0]         state_dbg;

    modport slave (
        input  digit_in, digit_strobe, clear, code_ack,
        output code_out, code_valid, digit_count, busy, timeout_err, overrun, state_dbg
    );

    modport master (
        output digit_in, digit_strobe, clear, code_ack,
        input  code_out, code_valid, digit_count, busy, timeout_err, overrun, state_dbg
    );
endinterface

// File: rtl/code_assembler.sv
// Assembles NUM_DIGITS strobed digits into one code word (first digit MS) and
// hands it on over code_valid/code_ack; stale partial entries abort on timeout.
module code_assembler #(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_W        = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    code_assembler_if.slave  bus
);
    localparam int W  = NUM_DIGITS * DIGIT_W;
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        READY   = 2'd2
    } state_t;

    state_t        state;
    logic          strobe_q;
    logic [TW-1:0] tmo_cnt;
    logic [W-1:0]  code_r;
    logic [CW-1:0] count_r;
    logic          valid_r;
    logic          tmo_r;
    logic          ovr_r;
    logic          ev;

    // One event per strobe assertion, however long the strobe is held.
    assign ev = bus.digit_strobe & ~strobe_q;

    // Handshake: code_valid rises one cycle after the completing digit and holds
    // code_out stable until a cycle with code_ack=1; that cycle is the transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            strobe_q <= 1'b0;
            tmo_cnt  <= '0;
            code_r   <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
            tmo_r    <= 1'b0;
            ovr_r    <= 1'b0;
        end else begin
            strobe_q <= bus.digit_strobe;
            tmo_r    <= 1'b0;
            ovr_r    <= 1'b0;
            if (bus.clear) begin
                state   <= IDLE;
                code_r  <= '0;
                count_r <= '0;
                valid_r <= 1'b0;
                tmo_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ev) begin
                            state   <= COLLECT;
                            code_r  <= W'(bus.digit_in);
                            count_r <= CW'(1);
                            tmo_cnt <= '0;
                        end
                    end
                    COLLECT: begin
                        if (ev) begin
                            code_r  <= {code_r[W-DIGIT_W-1:0], bus.digit_in};
                            count_r <= count_r + CW'(1);
                            tmo_cnt <= '0;
                            if (count_r == CW'(NUM_DIGITS - 1)) begin
                                state   <= READY;
                                valid_r <= 1'b1;
                            end
                        end else if (TMO_EN && tmo_cnt == TMO_LAST) begin
                            state   <= IDLE;
                            code_r  <= '0;
                            count_r <= '0;
                            tmo_cnt <= '0;
                            tmo_r   <= 1'b1;
                        end else if (TMO_EN) begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                    READY: begin
                        if (bus.code_ack) begin
                            valid_r <= 1'b0;
                            tmo_cnt <= '0;
                            if (ev) begin
                                state   <= COLLECT;
                                code_r  <= W'(bus.digit_in);
                                count_r <= CW'(1);
                            end else begin
                                state   <= IDLE;
                                code_r  <= '0;
                                count_r <= '0;
                            end
                        end else if (ev) begin
                            ovr_r <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        code_r  <= '0;
                        count_r <= '0;
                        valid_r <= 1'b0;
                        tmo_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.code_out    = code_r;
    assign bus.code_valid  = valid_r;
    assign bus.digit_count = count_r;
    assign bus.busy        = (state == COLLECT);
    assign bus.timeout_err = tmo_r;
    assign bus.overrun     = ovr_r;
    assign bus.state_dbg   = state;
endmodule
